op_arbiter: RTL and testbench
=============================

OP_ARBITER -- requirements
Module: op_arbiter

Interface
REQ-001 Parameter NUM_SIZE, default 32: operand/result width, signed two's complement.
REQ-002 Parameter CMD_SIZE_LOG2, default 3: cmd width is 2**CMD_SIZE_LOG2 bits.
REQ-003 Parameter NOOP_CMD, default 0: opcode driven to datapath when idle.
REQ-004 clk  in  1  sole clock; all state updates on posedge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 reqN_valid  in  1  requester N (N=0,1) presents an op.
REQ-007 reqN_ready  out  1  op accepted on cycle where reqN_valid && reqN_ready.
REQ-008 reqN_in1, reqN_in2  in  NUM_SIZE  operands, signed.
REQ-009 reqN_cmd  in  2**CMD_SIZE_LOG2  opcode.
REQ-010 rspN_valid  out  1  result slot N holds a result.
REQ-011 rspN_ready  in  1  requester N consumes result.
REQ-012 rspN_data  out  NUM_SIZE  result for requester N.
REQ-013 alu_in1, alu_in2  out  NUM_SIZE  registered operands to shared datapath.
REQ-014 alu_cmd  out  2**CMD_SIZE_LOG2  registered opcode to shared datapath.
REQ-015 alu_out  in  NUM_SIZE  datapath result, valid one cycle after alu_in*/alu_cmd.
REQ-016 op_count  out  16  count of results written into slots.

Function
REQ-017 At most one op is accepted per cycle across both requesters.
REQ-018 Requester N is eligible when: no op for N in pipeline stage S1 or S2, and (slot N empty or rspN_valid && rspN_ready this cycle).
REQ-019 reqN_ready = eligible_N && grant_N; combinational from state, rspN_ready and both reqN_valid.
REQ-020 Arbitration round-robin: one valid+eligible requester wins; both valid+eligible -> the one not granted most recently wins.
REQ-021 Round-robin pointer updates only on an accepted op; no grant leaves it unchanged.
REQ-022 Op accepted in cycle c: alu_in1/alu_in2/alu_cmd hold it in cycle c+1 (stage S1, tag N).
REQ-023 Cycle c+2: stage S2 holds tag N; alu_out captured into slot N at end of c+2.
REQ-024 rspN_valid high and rspN_data valid from cycle c+3; held stable until rspN_valid && rspN_ready.
REQ-025 Slot N write and drain never coincide (REQ-018); slot clears at end of the drain cycle.
REQ-026 Cycle with no accepted op: alu_in1 = 0, alu_in2 = 0, alu_cmd = NOOP_CMD next cycle; S1 valid low.
REQ-027 Results pass through unmodified; width NUM_SIZE, overflow wraps as datapath produces it.
REQ-028 op_count increments by 1 per slot write; wraps 0xFFFF -> 0x0000.
REQ-029 Minimum per-requester repeat interval is 3 cycles (accept c, next accept earliest c+3 with same-cycle drain).
REQ-030 Ops with opcodes other than NOOP_CMD are issued unchanged; result is whatever alu_out returns.

Reset
REQ-031 While reset is high: reqN_ready = 0, rspN_valid = 0, rspN_data = 0, alu_in1 = alu_in2 = 0, alu_cmd = NOOP_CMD, op_count = 0.
REQ-032 Reset discards S1, S2 and both slots; no result of a pre-reset op appears afterward.
REQ-033 Round-robin pointer resets so requester 0 wins the first contended cycle.
REQ-034 First op may be accepted in the first cycle reset is low.

Verification
REQ-035 req0 (in1=5, in2=7, cmd=0) accepted cycle c, rsp0_ready=1 -> rsp0_valid=1, rsp0_data=12 in c+3 only; rsp1_valid stays 0; op_count=1.
REQ-036 After reset, req0 (3,4) and req1 (10,-2) valid same cycle c -> req0 accepted c, req1 c+1; rsp0_data=7 at c+3, rsp1_data=8 at c+4.
REQ-037 rsp0_ready=0 for 10 cycles with req0_valid held -> req0_ready stays 0; rsp0_data stable; raising rsp0_ready -> next req0 accepted same cycle as drain.
REQ-038 req1 (0x7FFFFFFF, 1) -> rsp1_data = 0x80000000.
REQ-039 req0 accepted c, reset high in c+1 -> rsp0_valid never rises; op_count=0; all outputs at reset values.
REQ-040 Both requesters continuously valid, responses always ready, 65536 results -> grants alternate 0,1,0,1...; op_count=0x0000 at end.

Source files
------------

// File: rtl/op_arbiter.sv
// Two-requester round-robin front end for a shared datapath with one-cycle latency.
// Each requester owns a single result slot; an op is issued only when its slot is free when the result lands.
module op_arbiter #(
    parameter int NUM_SIZE      = 32,
    parameter int CMD_SIZE_LOG2 = 3,
    parameter int NOOP_CMD      = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req0_valid,
    output logic                          req0_ready,
    input  logic [NUM_SIZE-1:0]           req0_in1,
    input  logic [NUM_SIZE-1:0]           req0_in2,
    input  logic [(2**CMD_SIZE_LOG2)-1:0] req0_cmd,
    input  logic                          req1_valid,
    output logic                          req1_ready,
    input  logic [NUM_SIZE-1:0]           req1_in1,
    input  logic [NUM_SIZE-1:0]           req1_in2,
    input  logic [(2**CMD_SIZE_LOG2)-1:0] req1_cmd,
    output logic                          rsp0_valid,
    input  logic                          rsp0_ready,
    output logic [NUM_SIZE-1:0]           rsp0_data,
    output logic                          rsp1_valid,
    input  logic                          rsp1_ready,
    output logic [NUM_SIZE-1:0]           rsp1_data,
    output logic [NUM_SIZE-1:0]           alu_in1,
    output logic [NUM_SIZE-1:0]           alu_in2,
    output logic [(2**CMD_SIZE_LOG2)-1:0] alu_cmd,
    input  logic [NUM_SIZE-1:0]           alu_out,
    output logic [15:0]                   op_count
);

    localparam int CW = 2**CMD_SIZE_LOG2;
    localparam logic [CW-1:0] NOOP = CW'(NOOP_CMD);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // ready never depends on the same-side data, and a response stays stable until taken.

    logic                s1_valid_q, s1_tag_q;
    logic                s2_valid_q, s2_tag_q;
    logic [NUM_SIZE-1:0] alu_in1_q, alu_in2_q;
    logic [CW-1:0]       alu_cmd_q;
    logic [1:0]          slot_valid_q;
    logic [NUM_SIZE-1:0] slot0_data_q, slot1_data_q;
    logic                last_grant_q;
    logic [15:0]         op_count_q;

    logic [1:0]          in_pipe, drain, eligible, cand, grant;
    logic                accept;

    // A requester with an op in S1 or S2 must wait: its slot would be written twice otherwise.
    always_comb begin
        in_pipe = 2'b00;
        if (s1_valid_q) in_pipe[s1_tag_q] = 1'b1;
        if (s2_valid_q) in_pipe[s2_tag_q] = 1'b1;
    end

    assign drain    = slot_valid_q & {rsp1_ready, rsp0_ready};
    assign eligible = ~in_pipe & (~slot_valid_q | drain) & {2{~reset}};
    assign cand     = eligible & {req1_valid, req0_valid};

    // last_grant_q names the requester that won most recently; the other one wins a tie.
    assign grant[0] = cand[0] & (~cand[1] | last_grant_q);
    assign grant[1] = cand[1] & (~cand[0] | ~last_grant_q);
    assign accept   = |grant;

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_tag_q     <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_tag_q     <= 1'b0;
            alu_in1_q    <= '0;
            alu_in2_q    <= '0;
            alu_cmd_q    <= NOOP;
            slot_valid_q <= 2'b00;
            slot0_data_q <= '0;
            slot1_data_q <= '0;
            last_grant_q <= 1'b1;
            op_count_q   <= 16'd0;
        end else begin
            s1_valid_q <= accept;
            s1_tag_q   <= grant[1];
            s2_valid_q <= s1_valid_q;
            s2_tag_q   <= s1_tag_q;

            if (grant[0]) begin
                alu_in1_q <= req0_in1;
                alu_in2_q <= req0_in2;
                alu_cmd_q <= req0_cmd;
            end else if (grant[1]) begin
                alu_in1_q <= req1_in1;
                alu_in2_q <= req1_in2;
                alu_cmd_q <= req1_cmd;
            end else begin
                alu_in1_q <= '0;
                alu_in2_q <= '0;
                alu_cmd_q <= NOOP;
            end

            if (accept) last_grant_q <= grant[1];

            if (s2_valid_q && !s2_tag_q) begin
                slot_valid_q[0] <= 1'b1;
                slot0_data_q    <= alu_out;
            end else if (drain[0]) begin
                slot_valid_q[0] <= 1'b0;
            end

            if (s2_valid_q && s2_tag_q) begin
                slot_valid_q[1] <= 1'b1;
                slot1_data_q    <= alu_out;
            end else if (drain[1]) begin
                slot_valid_q[1] <= 1'b0;
            end

            if (s2_valid_q) op_count_q <= op_count_q + 16'd1;
        end
    end

    // Outputs read as reset values for every cycle reset is high, including the first.
    assign rsp0_valid = slot_valid_q[0] & ~reset;
    assign rsp1_valid = slot_valid_q[1] & ~reset;
    assign rsp0_data  = reset ? '0 : slot0_data_q;
    assign rsp1_data  = reset ? '0 : slot1_data_q;
    assign alu_in1    = reset ? '0 : alu_in1_q;
    assign alu_in2    = reset ? '0 : alu_in2_q;
    assign alu_cmd    = reset ? NOOP : alu_cmd_q;
    assign op_count   = reset ? 16'd0 : op_count_q;

endmodule

// File: tb/tb_op_arbiter.sv
// Randomised bench for op_arbiter: a datapath stand-in, a grant/eligibility model,
// and a per-requester expected-result queue drained by a negedge monitor.
module tb_op_arbiter;

    localparam int W  = 32;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid [2];
    logic [W-1:0]  req_in1 [2];
    logic [W-1:0]  req_in2 [2];
    logic [CW-1:0] req_cmd [2];
    logic          rsp_ready [2];
    logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [W-1:0]  rsp0_data, rsp1_data;
    logic [W-1:0]  alu_in1, alu_in2, alu_out;
    logic [CW-1:0] alu_cmd;
    logic [15:0]   op_count;

    op_arbiter #(.NUM_SIZE(W), .CMD_SIZE_LOG2(3), .NOOP_CMD(0)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req_valid[0]), .req0_ready(req0_ready), .req0_in1(req_in1[0]),
        .req0_in2(req_in2[0]), .req0_cmd(req_cmd[0]),
        .req1_valid(req_valid[1]), .req1_ready(req1_ready), .req1_in1(req_in1[1]),
        .req1_in2(req_in2[1]), .req1_cmd(req_cmd[1]),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp_ready[0]), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp_ready[1]), .rsp1_data(rsp1_data),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_cmd(alu_cmd), .alu_out(alu_out),
        .op_count(op_count)
    );

    // ---------------- clock / datapath stand-in ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [CW-1:0] c);
        case (c)
            8'd0:    return a + b;
            8'd1:    return a - b;
            8'd2:    return a & b;
            8'd3:    return a | b;
            8'd4:    return a ^ b;
            default: return a + (b ^ {24'd0, c});
        endcase
    endfunction

    always @(posedge clk) alu_out <= alu_fn(alu_in1, alu_in2, alu_cmd);

    // ---------------- scoreboard state ----------------
    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q0[$], exp_q1[$];
    int           acc_q0[$], acc_q1[$];
    logic         head_seen [2];
    logic [15:0]  exp_count = 16'd0;
    logic [W-1:0] alu_next_a = '0, alu_next_b = '0, alu_pend_a = '0, alu_pend_b = '0;
    logic [CW-1:0] alu_next_c = '0, alu_pend_c = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int qsize(input int n);
        return (n == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic int head_acc(input int n);
        if (n == 0) return (acc_q0.size() > 0) ? acc_q0[0] : 0;
        return (acc_q1.size() > 0) ? acc_q1[0] : 0;
    endfunction

    function automatic logic [W-1:0] head_data(input int n);
        if (n == 0) return (exp_q0.size() > 0) ? exp_q0[0] : '0;
        return (exp_q1.size() > 0) ? exp_q1[0] : '0;
    endfunction

    // ---------------- driver ----------------
    logic          rst_want = 1'b1;
    logic          rand_rsp = 1'b0;
    logic          rsp_want [2];
    int            p_valid = 0, p_ready = 100;
    logic          acc_flag [2];
    logic          dir_pend [2];
    logic [W-1:0]  dir_a [2], dir_b [2];
    logic [CW-1:0] dir_c [2];
    logic          last_g = 1'b1;
    logic          alt_mode = 1'b0, have_prev = 1'b0, prev_tag = 1'b0;

    task automatic present(input int n, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [CW-1:0] c);
        dir_pend[n] = 1'b1;
        dir_a[n] = a;
        dir_b[n] = b;
        dir_c[n] = c;
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Expected grant: eligible if nothing outstanding, or the outstanding result is already
    // resident (three cycles after acceptance) and is being consumed this cycle.
    task automatic check_and_push();
        logic got [2];
        logic elig [2];
        logic cand [2];
        logic exp_rdy [2];
        got[0] = req0_ready;
        got[1] = req1_ready;
        alu_next_a = '0;
        alu_next_b = '0;
        alu_next_c = '0;
        if (reset) begin
            chk("ready0_in_reset", got[0], 0);
            chk("ready1_in_reset", got[1], 0);
            exp_q0.delete(); exp_q1.delete(); acc_q0.delete(); acc_q1.delete();
            last_g = 1'b1;
            have_prev = 1'b0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                elig[n] = (qsize(n) == 0) || (cyc >= head_acc(n) + 3 && rsp_ready[n]);
                cand[n] = req_valid[n] && elig[n];
            end
            exp_rdy[0] = cand[0] && (!cand[1] || last_g == 1'b1);
            exp_rdy[1] = cand[1] && (!cand[0] || last_g == 1'b0);
            chk("req0_ready", got[0], exp_rdy[0]);
            chk("req1_ready", got[1], exp_rdy[1]);
            for (int n = 0; n < 2; n++) begin
                if (req_valid[n] && got[n]) begin
                    if (n == 0) begin
                        exp_q0.push_back(alu_fn(req_in1[0], req_in2[0], req_cmd[0]));
                        acc_q0.push_back(cyc);
                    end else begin
                        exp_q1.push_back(alu_fn(req_in1[1], req_in2[1], req_cmd[1]));
                        acc_q1.push_back(cyc);
                    end
                    if (alt_mode && have_prev) chk("alternate_grant", n, !prev_tag);
                    prev_tag = (n == 1);
                    have_prev = 1'b1;
                    last_g = (n == 1);
                    acc_flag[n] = 1'b1;
                    alu_next_a = req_in1[n];
                    alu_next_b = req_in2[n];
                    alu_next_c = req_cmd[n];
                end
            end
        end
    endtask

    task automatic drive_cycle();
        @(posedge clk);
        #1;
        reset = rst_want;
        for (int n = 0; n < 2; n++) begin
            if (acc_flag[n] || reset) begin
                req_valid[n] = 1'b0;
                acc_flag[n] = 1'b0;
            end
            if (!req_valid[n]) begin
                if (dir_pend[n]) begin
                    req_in1[n] = dir_a[n];
                    req_in2[n] = dir_b[n];
                    req_cmd[n] = dir_c[n];
                    req_valid[n] = 1'b1;
                    dir_pend[n] = 1'b0;
                end else if ($urandom_range(0, 99) < p_valid) begin
                    req_in1[n] = rand_operand();
                    req_in2[n] = rand_operand();
                    req_cmd[n] = 8'($urandom_range(0, 7));
                    req_valid[n] = 1'b1;
                end
            end
            rsp_ready[n] = rand_rsp ? ($urandom_range(0, 99) < p_ready) : rsp_want[n];
        end
        #2;
        check_and_push();
    endtask

    task automatic run(input int n_cycles);
        for (int i = 0; i < n_cycles; i++) drive_cycle();
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic rv;
        logic [W-1:0] rd;
        if (reset) begin
            chk("rsp0_valid_in_reset", rsp0_valid, 0);
            chk("rsp1_valid_in_reset", rsp1_valid, 0);
            chk("rsp_data_in_reset", {rsp1_data, rsp0_data}, 0);
            chk("alu_in_in_reset", {alu_in1, alu_in2}, 0);
            chk("alu_cmd_in_reset", alu_cmd, 0);
            chk("op_count_in_reset", op_count, 0);
            exp_count = 16'd0;
            head_seen[0] = 1'b0;
            head_seen[1] = 1'b0;
        end else begin
            chk("alu_in1", alu_in1, alu_pend_a);
            chk("alu_in2", alu_in2, alu_pend_b);
            chk("alu_cmd", alu_cmd, alu_pend_c);
            for (int n = 0; n < 2; n++) begin
                rv = (n == 0) ? rsp0_valid : rsp1_valid;
                rd = (n == 0) ? rsp0_data : rsp1_data;
                if (!head_seen[n]) begin
                    if (qsize(n) > 0 && cyc == head_acc(n) + 3) begin
                        chk(n == 0 ? "rsp0_latency" : "rsp1_latency", rv, 1);
                        head_seen[n] = 1'b1;
                        exp_count = exp_count + 16'd1;
                    end else begin
                        chk(n == 0 ? "rsp0_spurious" : "rsp1_spurious", rv, 0);
                    end
                end
                if (head_seen[n]) begin
                    chk(n == 0 ? "rsp0_hold_valid" : "rsp1_hold_valid", rv, 1);
                    chk(n == 0 ? "rsp0_data" : "rsp1_data", rd, head_data(n));
                    if (rv && rsp_ready[n]) begin
                        if (n == 0) begin void'(exp_q0.pop_front()); void'(acc_q0.pop_front()); end
                        else begin void'(exp_q1.pop_front()); void'(acc_q1.pop_front()); end
                        head_seen[n] = 1'b0;
                    end
                end
            end
            chk("op_count", op_count, exp_count);
        end
        alu_pend_a = alu_next_a;
        alu_pend_b = alu_next_b;
        alu_pend_c = alu_next_c;
    end

    // ---------------- stimulus sequence ----------------
    initial begin
        for (int n = 0; n < 2; n++) begin
            req_valid[n] = 1'b0; req_in1[n] = '0; req_in2[n] = '0; req_cmd[n] = '0;
            rsp_ready[n] = 1'b1; rsp_want[n] = 1'b1; acc_flag[n] = 1'b0;
            dir_pend[n] = 1'b0; head_seen[n] = 1'b0;
            dir_a[n] = '0; dir_b[n] = '0; dir_c[n] = '0;
        end
        run(3);

        // Contended first cycle after reset: requester 0 first, requester 1 next cycle.
        rst_want = 1'b0;
        present(0, 32'd3, 32'd4, 8'd0);
        present(1, 32'd10, -32'sd2, 8'd0);
        run(8);

        present(0, 32'd5, 32'd7, 8'd0);
        run(6);
        present(1, 32'h7FFF_FFFF, 32'd1, 8'd0);
        run(6);

        // Back-pressure on slot 0 while requester 0 keeps asking.
        rsp_want[0] = 1'b0;
        present(0, 32'd1, 32'd2, 8'd1);
        run(5);
        present(0, 32'd9, 32'd9, 8'd4);
        run(10);
        rsp_want[0] = 1'b1;
        run(6);

        // Reset right after an acceptance discards the in-flight op.
        present(0, 32'd2, 32'd2, 8'd0);
        run(1);
        rst_want = 1'b1;
        run(2);
        rst_want = 1'b0;
        run(6);

        rand_rsp = 1'b1;
        p_valid = 60;
        p_ready = 70;
        run(1500);
        rst_want = 1'b1;
        run(1);
        rst_want = 1'b0;
        p_ready = 40;
        run(1500);

        // Saturated traffic with responses always taken: grants must alternate.
        p_valid = 100;
        p_ready = 100;
        alt_mode = 1'b1;
        have_prev = 1'b0;
        run(2000);
        alt_mode = 1'b0;

        p_valid = 0;
        for (int i = 0; i < 40 && (qsize(0) + qsize(1)) > 0; i++) drive_cycle();
        chk("drain_outstanding", qsize(0) + qsize(1), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
